ram_arb_2to1: RTL and testbench

- Two-requester arbiter sharing one single-port synchronous RAM (ram_1rw_sync behind its valid/ready/wr_en wrapper interface) between port 0 (instruction fetch) and port 1 (load/store).
- Grants one request per accepted memory handshake and holds the grant stable while the memory stalls.
- Records the owner of each outstanding read in a small owner FIFO and routes each read response back to the port that issued it.

---
 rtl/ram_arb_2to1.sv | 232 +++++++++++++++++++++++
 tb/tb_ram_arb_2to1.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb_2to1.sv
// ram_arb_2to1: two-port arbiter in front of one single-port synchronous RAM.
// Port 0 (fetch) and port 1 (load/store) share the RAM through a valid/ready
// handshake. A small owner FIFO remembers which port issued each outstanding
// read, so in-order read responses are steered back to the right port.
//
// Build option: define RAM_ARB_FIXED_PRIO_EN to make port 0 always win a new
// arbitration; the round-robin pointer then disappears. The stall lock (HOLD)
// behaves the same in both builds.
module ram_arb_2to1 #(
  parameter int AddrWidth      = 8,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // port 0 (instruction fetch)
  input  logic                   p0_valid_i,
  output logic                   p0_ready_o,
  input  logic [AddrWidth-1:0]   p0_addr_i,
  input  logic [DataWidth-1:0]   p0_wr_data_i,
  input  logic [DataWidth/8-1:0] p0_wr_en_i,
  output logic [DataWidth-1:0]   p0_rd_data_o,
  output logic                   p0_rd_valid_o,
  // port 1 (load/store)
  input  logic                   p1_valid_i,
  output logic                   p1_ready_o,
  input  logic [AddrWidth-1:0]   p1_addr_i,
  input  logic [DataWidth-1:0]   p1_wr_data_i,
  input  logic [DataWidth/8-1:0] p1_wr_en_i,
  output logic [DataWidth-1:0]   p1_rd_data_o,
  output logic                   p1_rd_valid_o,
  // RAM side
  output logic                   mem_valid_o,
  input  logic                   mem_ready_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wr_data_o,
  output logic [DataWidth/8-1:0] mem_wr_en_o,
  input  logic [DataWidth-1:0]   mem_rd_data_i,
  input  logic                   mem_rd_valid_i,
  // sticky unexpected-response flag
  output logic                   err_o
);

  localparam int MaskWidth = DataWidth / 8;
  localparam int PtrW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW      = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   lock_q, lock_d;

  // owner FIFO: one bit per outstanding read (0 = port 0, 1 = port 1)
  logic [(1<<PtrW)-1:0] owner_q;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;

  // err_q is the sticky error; armed_q opens the error check once the first
  // post-reset request has been accepted, so stale responses are ignored.
  logic err_q, err_d;
  logic armed_q, armed_d;

  // selection / handshake
  logic                 win;
  logic                 win_valid;
  logic [AddrWidth-1:0] win_addr;
  logic [DataWidth-1:0] win_data;
  logic [MaskWidth-1:0] win_mask;
  logic                 win_is_write;
  logic                 can_issue;
  logic                 issue;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 head;
  logic                 fifo_empty;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic prio_q, prio_d;
`endif

  // Pick the port that drives the RAM: the locked port while stalled,
  // otherwise the arbitration winner among valid requesters.
  always_comb begin
    win = 1'b0;
    if (state_q == ST_HOLD) begin
      win = lock_q;
    end else begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      win = p0_valid_i ? 1'b0 : 1'b1;
`else
      if (p0_valid_i && p1_valid_i) begin
        win = prio_q;
      end else begin
        win = p0_valid_i ? 1'b0 : 1'b1;
      end
`endif
    end
  end

  // Request mux and issue qualification; a read needs a free owner slot,
  // a write never waits on outstanding reads. The response path does not
  // feed this logic, so mem_rd_valid_i never reaches any ready_o.
  always_comb begin
    win_valid    = win ? p1_valid_i   : p0_valid_i;
    win_addr     = win ? p1_addr_i    : p0_addr_i;
    win_data     = win ? p1_wr_data_i : p0_wr_data_i;
    win_mask     = win ? p1_wr_en_i   : p0_wr_en_i;
    win_is_write = |win_mask;
    can_issue    = (count_q < CntMax) || win_is_write;
    issue        = win_valid && can_issue && !rst_i;
    accept       = issue && mem_ready_i;
  end

  // Next-state logic for the arbitration FSM (lock and priority included).
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      ST_ARB: begin
        if (issue && !mem_ready_i) begin
          lock_d  = win;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
`ifndef RAM_ARB_FIXED_PRIO_EN
    if (accept) begin
      prio_d = ~win;
    end
`endif
  end

  // Owner FIFO bookkeeping and error detection.
  always_comb begin
    fifo_empty = (count_q == '0);
    head       = owner_q[rd_ptr_q];
    push       = accept && !win_is_write;
    pop        = mem_rd_valid_i && !fifo_empty;

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    armed_d = armed_q || accept;
    err_d   = err_q || (mem_rd_valid_i && fifo_empty && armed_q);
  end

  // Output drive; everything is forced low while reset is held.
  always_comb begin
    mem_valid_o   = issue;
    mem_addr_o    = rst_i ? '0 : win_addr;
    mem_wr_data_o = rst_i ? '0 : win_data;
    mem_wr_en_o   = rst_i ? '0 : win_mask;
    p0_ready_o    = accept && (win == 1'b0);
    p1_ready_o    = accept && (win == 1'b1);
    p0_rd_valid_o = !rst_i && mem_rd_valid_i && !fifo_empty && (head == 1'b0);
    p1_rd_valid_o = !rst_i && mem_rd_valid_i && !fifo_empty && (head == 1'b1);
    p0_rd_data_o  = rst_i ? '0 : mem_rd_data_i;
    p1_rd_data_o  = rst_i ? '0 : mem_rd_data_i;
    err_o         = err_q;
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_ARB;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
    end
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Round-robin pointer: starts with port 0 favoured after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  // Owner slot storage; only entries below count are ever consulted.
  always_ff @(posedge clk_i) begin
    if (push) begin
      owner_q[wr_ptr_q] <= win;
    end
  end

endmodule

// File: tb/tb_ram_arb_2to1.sv
// Bench for ram_arb_2to1: directed scenarios with literal expectations plus a
// transaction-level model (queue of read owners) compared every cycle.
module tb_ram_arb_2to1;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MW   = DW / 8;
  localparam int MAXO = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          p0_valid_i, p1_valid_i;
  logic          p0_ready_o, p1_ready_o;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [DW-1:0] p0_wr_data_i, p1_wr_data_i;
  logic [MW-1:0] p0_wr_en_i, p1_wr_en_i;
  logic [DW-1:0] p0_rd_data_o, p1_rd_data_o;
  logic          p0_rd_valid_o, p1_rd_valid_o;
  logic          mem_valid_o, mem_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wr_data_o;
  logic [MW-1:0] mem_wr_en_o;
  logic [DW-1:0] mem_rd_data_i;
  logic          mem_rd_valid_i;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  ram_arb_2to1 #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_valid_i(p0_valid_i), .p0_ready_o(p0_ready_o), .p0_addr_i(p0_addr_i),
    .p0_wr_data_i(p0_wr_data_i), .p0_wr_en_i(p0_wr_en_i),
    .p0_rd_data_o(p0_rd_data_o), .p0_rd_valid_o(p0_rd_valid_o),
    .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o), .p1_addr_i(p1_addr_i),
    .p1_wr_data_i(p1_wr_data_i), .p1_wr_en_i(p1_wr_en_i),
    .p1_rd_data_o(p1_rd_data_o), .p1_rd_valid_o(p1_rd_valid_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_rd_data_i(mem_rd_data_i), .mem_rd_valid_i(mem_rd_valid_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_hold, m_lock, m_prio, m_err, m_armed;
  int m_q[$];
  bit e_w, e_wv, e_wr, e_mv, e_acc, e_r0, e_r1;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [MW-1:0] e_mask;

  always @(negedge clk_i) begin
    if (rst_i) begin
      m_hold = 0; m_lock = 0; m_prio = 0; m_err = 0; m_armed = 0;
      m_q.delete();
      chk("rst_mem_valid", mem_valid_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_p0_ready", p0_ready_o, 0);
      chk("rst_p1_ready", p1_ready_o, 0);
      chk("rst_p0_rd_valid", p0_rd_valid_o, 0);
      chk("rst_p1_rd_valid", p1_rd_valid_o, 0);
      chk("rst_err", err_o, 0);
    end else begin
      if (m_hold) e_w = m_lock;
`ifdef RAM_ARB_FIXED_PRIO_EN
      else e_w = p0_valid_i ? 1'b0 : 1'b1;
`else
      else if (p0_valid_i && p1_valid_i) e_w = m_prio;
      else e_w = p0_valid_i ? 1'b0 : 1'b1;
`endif
      e_wv   = e_w ? p1_valid_i : p0_valid_i;
      e_addr = e_w ? p1_addr_i : p0_addr_i;
      e_data = e_w ? p1_wr_data_i : p0_wr_data_i;
      e_mask = e_w ? p1_wr_en_i : p0_wr_en_i;
      e_wr   = (e_mask != 0);
      e_mv   = e_wv && (e_wr || m_q.size() < MAXO);
      e_acc  = e_mv && mem_ready_i;
      e_r0   = mem_rd_valid_i && m_q.size() > 0 && m_q[0] == 0;
      e_r1   = mem_rd_valid_i && m_q.size() > 0 && m_q[0] == 1;

      chk("m_mem_valid", mem_valid_o, e_mv);
      if (e_mv) begin
        chk("m_mem_addr", mem_addr_o, e_addr);
        chk("m_mem_wr_en", mem_wr_en_o, e_mask);
        if (e_wr) chk("m_mem_wr_data", mem_wr_data_o, e_data);
      end
      chk("m_p0_ready", p0_ready_o, e_acc && !e_w);
      chk("m_p1_ready", p1_ready_o, e_acc && e_w);
      chk("m_p0_rd_valid", p0_rd_valid_o, e_r0);
      chk("m_p1_rd_valid", p1_rd_valid_o, e_r1);
      chk("m_p0_rd_data", p0_rd_data_o, mem_rd_data_i);
      chk("m_p1_rd_data", p1_rd_data_o, mem_rd_data_i);
      chk("m_err", err_o, m_err);

      if (mem_rd_valid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else if (m_armed) m_err = 1;
      end
      if (e_acc) begin
        if (!e_wr) m_q.push_back(int'(e_w));
        m_armed = 1;
        m_prio  = ~e_w;
        m_hold  = 0;
      end else if (e_mv && !m_hold) begin
        m_hold = 1;
        m_lock = e_w;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    p0_valid_i = 0; p0_addr_i = '0; p0_wr_data_i = '0; p0_wr_en_i = '0;
    p1_valid_i = 0; p1_addr_i = '0; p1_wr_data_i = '0; p1_wr_en_i = '0;
    mem_ready_i = 0; mem_rd_valid_i = 0; mem_rd_data_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    step();
    rst_i = 0;
  endtask

  int acc0, acc1;

  initial begin
    idle();
    rst_i = 1;
    step();
    step();
    rst_i = 0;

    // single read from port 0
    p0_valid_i = 1; p0_addr_i = 8'h10; mem_ready_i = 1;
    @(negedge clk_i);
    chk("t1_mem_valid", mem_valid_o, 1);
    chk("t1_mem_addr", mem_addr_o, 8'h10);
    chk("t1_p0_ready", p0_ready_o, 1);
    chk("t1_p1_ready", p1_ready_o, 0);
    step();
    idle(); mem_rd_valid_i = 1; mem_rd_data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("t1_p0_rd_valid", p0_rd_valid_o, 1);
    chk("t1_p1_rd_valid", p1_rd_valid_o, 0);
    chk("t1_p0_rd_data", p0_rd_data_o, 32'hDEADBEEF);
    step();

`ifndef RAM_ARB_FIXED_PRIO_EN
    // contention: both read every cycle, RAM answers one cycle later
    do_reset();
    acc0 = 0; acc1 = 0;
    for (int k = 0; k < 5; k++) begin
      p0_valid_i = (k < 4); p0_addr_i = 8'h20;
      p1_valid_i = (k < 4); p1_addr_i = 8'h30;
      mem_ready_i = 1;
      mem_rd_valid_i = (k > 0); mem_rd_data_i = 32'h100 + k;
      @(negedge clk_i);
      if (k < 4) begin
        chk("cont_p0_ready", p0_ready_o, (k % 2) == 0);
        chk("cont_p1_ready", p1_ready_o, (k % 2) == 1);
      end
      if (k > 0) begin
        chk("cont_p0_rd_valid", p0_rd_valid_o, ((k - 1) % 2) == 0);
        chk("cont_p1_rd_valid", p1_rd_valid_o, ((k - 1) % 2) == 1);
      end
      acc0 += int'(p0_ready_o);
      acc1 += int'(p1_ready_o);
      step();
    end
    chk("cont_p0_accepts", acc0, 2);
    chk("cont_p1_accepts", acc1, 2);
`endif

    // stall lock: p1 wins, RAM stalls three cycles while p0 waits
    do_reset();
    p1_valid_i = 1; p1_addr_i = 8'h44; mem_ready_i = 0;
    @(negedge clk_i);
    chk("stall_mem_valid", mem_valid_o, 1);
    chk("stall_addr0", mem_addr_o, 8'h44);
    step();
    for (int k = 0; k < 2; k++) begin
      p0_valid_i = 1; p0_addr_i = 8'h40;
      @(negedge clk_i);
      chk("stall_addr_held", mem_addr_o, 8'h44);
      chk("stall_p0_ready", p0_ready_o, 0);
      chk("stall_p1_ready", p1_ready_o, 0);
      step();
    end
    mem_ready_i = 1;
    @(negedge clk_i);
    chk("stall_p1_accept", p1_ready_o, 1);
    chk("stall_p0_blocked", p0_ready_o, 0);
    chk("stall_addr_acc", mem_addr_o, 8'h44);
    step();
    p1_valid_i = 0;
    @(negedge clk_i);
    chk("stall_p0_next", p0_ready_o, 1);
    chk("stall_p0_addr", mem_addr_o, 8'h40);
    step();
    p0_valid_i = 0; mem_rd_valid_i = 1; mem_rd_data_i = 32'hA1;
    @(negedge clk_i);
    chk("stall_resp_p1", p1_rd_valid_o, 1);
    chk("stall_resp_p1_not_p0", p0_rd_valid_o, 0);
    step();
    mem_rd_data_i = 32'hA0;
    @(negedge clk_i);
    chk("stall_resp_p0", p0_rd_valid_o, 1);
    step();

    // outstanding limit
    do_reset();
    mem_ready_i = 1;
    p0_valid_i = 1; p0_addr_i = 8'h01;
    step();
    p0_addr_i = 8'h02;
    step();
    p0_addr_i = 8'h03;
    @(negedge clk_i);
    chk("lim_read_blocked", mem_valid_o, 0);
    chk("lim_p0_ready", p0_ready_o, 0);
    step();
    p0_valid_i = 0;
    p1_valid_i = 1; p1_addr_i = 8'h55; p1_wr_en_i = 4'hF; p1_wr_data_i = 32'h12345678;
    @(negedge clk_i);
    chk("lim_write_valid", mem_valid_o, 1);
    chk("lim_write_ready", p1_ready_o, 1);
    chk("lim_write_data", mem_wr_data_o, 32'h12345678);
    chk("lim_write_mask", mem_wr_en_o, 4'hF);
    step();
    p1_valid_i = 0; p1_wr_en_i = 0;
    p0_valid_i = 1; p0_addr_i = 8'h03;
    mem_rd_valid_i = 1; mem_rd_data_i = 32'h11;
    @(negedge clk_i);
    chk("lim_resp_p0", p0_rd_valid_o, 1);
    chk("lim_still_blocked", mem_valid_o, 0);
    step();
    mem_rd_valid_i = 0;
    @(negedge clk_i);
    chk("lim_slot_freed", p0_ready_o, 1);
    step();
    p0_valid_i = 0; mem_rd_valid_i = 1;
    step();
    step();
    idle();
    step();

    // spurious response sets sticky error
    mem_rd_valid_i = 1; mem_rd_data_i = 32'h5A;
    @(negedge clk_i);
    chk("spur_no_p0_rd", p0_rd_valid_o, 0);
    chk("spur_no_p1_rd", p1_rd_valid_o, 0);
    step();
    mem_rd_valid_i = 0;
    @(negedge clk_i);
    chk("spur_err_set", err_o, 1);
    step();
    @(negedge clk_i);
    chk("spur_err_sticky", err_o, 1);

    // two reads outstanding, then reset mid-operation
    mem_ready_i = 1;
    p0_valid_i = 1; p0_addr_i = 8'h07;
    p1_valid_i = 1; p1_addr_i = 8'h08;
    step();
    step();
    rst_i = 1;
    @(negedge clk_i);
    chk("rst_mid_mem_valid", mem_valid_o, 0);
    chk("rst_mid_p0_ready", p0_ready_o, 0);
    step();
    idle();
    rst_i = 0;
    @(negedge clk_i);
    chk("rst_mid_err_clear", err_o, 0);
    step();
    mem_rd_valid_i = 1;
    @(negedge clk_i);
    chk("stale_no_p0_rd", p0_rd_valid_o, 0);
    chk("stale_no_p1_rd", p1_rd_valid_o, 0);
    step();
    mem_rd_valid_i = 0;
    @(negedge clk_i);
    chk("stale_no_err", err_o, 0);
    step();

`ifdef RAM_ARB_FIXED_PRIO_EN
    // fixed priority: p0 wins every cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      p0_valid_i = 1; p0_addr_i = 8'h60;
      p1_valid_i = 1; p1_addr_i = 8'h70;
      mem_ready_i = 1; mem_rd_valid_i = (k > 0);
      @(negedge clk_i);
      chk("fix_p0_ready", p0_ready_o, 1);
      chk("fix_p1_ready", p1_ready_o, 0);
      step();
    end
    idle();
    mem_rd_valid_i = 1;
    step();
    idle();
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
